// File: rtl/dbns_pkg.sv
// Shared constants, power-of-3 tables and FSM state type for the DBNS encoder.
// Imported by the encoder interface, candidate datapath and FSM top.
package dbns_pkg;

  localparam int DW   = 16;
  localparam int BMAX = 10;
  localparam int AW   = 4;
  localparam int BW   = 4;
  localparam int PW   = DW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT
  } state_e;

  localparam logic [DW-1:0] POW3 [0:BMAX] = '{
    16'd1,    16'd3,    16'd9,
    16'd27,   16'd81,   16'd243,
    16'd729,  16'd2187, 16'd6561,
    16'd19683, 16'd59049
  };

  localparam logic [AW-1:0] MSB3 [0:BMAX] = '{
    4'd0,  4'd1,  4'd3,  4'd4,
    4'd6,  4'd7,  4'd9,  4'd11,
    4'd12, 4'd14, 4'd15
  };

  function automatic logic [AW-1:0] msb_idx(
    input logic [DW-1:0] v
  );
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++)
      if (v[i]) r = AW'(i);
    return r;
  endfunction

endpackage

// File: rtl/dbns_encoder_if.sv
// Operand-in / term-out valid-ready bundle of the DBNS encoder.
// slave: encoder side; master: producer/consumer side.
interface dbns_encoder_if;
  import dbns_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_a;
  logic [BW-1:0] out_b;
  logic          out_zero;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a,
    output out_b, out_zero, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a,
    input  out_b, out_zero, out_last
  );

endinterface

// File: rtl/dbns_term_cand.sv
// Largest 2^a*3^bidx <= rem for one ternary exponent (combinational).
// In: rem_i, bidx_i. Out: cand_o, a_c_o, cand_valid_o.
module dbns_term_cand
  import dbns_pkg::*;
(
  input  logic [DW-1:0] rem_i,
  input  logic [BW-1:0] bidx_i,
  output logic [PW-1:0] cand_o,
  output logic [AW-1:0] a_c_o,
  output logic          cand_valid_o
);

  logic [PW-1:0] p3;
  logic [PW-1:0] rem_x;
  logic [PW-1:0] sh;
  logic [AW-1:0] ac;

  always_comb begin
    p3           = {1'b0, POW3[bidx_i]};
    rem_x        = {1'b0, rem_i};
    cand_valid_o = (p3 <= rem_x);
    ac           = '0;
    if (cand_valid_o)
      ac = msb_idx(rem_i) - MSB3[bidx_i];
    // aligning msbs can overshoot by one bit
    sh     = p3 << ac;
    cand_o = sh;
    a_c_o  = ac;
    if (sh > rem_x) begin
      cand_o = sh >> 1;
      a_c_o  = ac - 1'b1;
    end
  end

endmodule

// File: rtl/dbns_encoder.sv
// Greedy binary-to-DBNS encoder: one ternary exponent scanned per clock.
// Ports: clk, rst (async active-low), bus (slave), busy.
module dbns_encoder
  import dbns_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dbns_encoder_if.slave  bus,
  output logic           busy
);

  state_e        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] best_q, best_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic          ov_q, ov_d;
  logic [AW-1:0] oa_q, oa_d;
  logic [BW-1:0] ob_q, ob_d;
  logic          oz_q, oz_d;
  logic          ol_q, ol_d;

  logic [PW-1:0] cand;
  logic [AW-1:0] a_c;
  logic          cand_valid;

  dbns_term_cand u_cand (
    .rem_i        (rem_q),
    .bidx_i       (bidx_q),
    .cand_o       (cand),
    .a_c_o        (a_c),
    .cand_valid_o (cand_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      best_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bidx_q  <= '0;
      ov_q    <= 1'b0;
      oa_q    <= '0;
      ob_q    <= '0;
      oz_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      best_q  <= best_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bidx_q  <= bidx_d;
      ov_q    <= ov_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      oz_q    <= oz_d;
      ol_q    <= ol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    best_d  = best_q;
    a_d     = a_q;
    b_d     = b_q;
    bidx_d  = bidx_q;
    ov_d    = ov_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    oz_d    = oz_q;
    ol_d    = ol_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rem_d   = bus.in_data;
          bidx_d  = '0;
          best_d  = '0;
          a_d     = '0;
          b_d     = '0;
          state_d = (bus.in_data == '0) ? EMIT : SEARCH;
        end
      end
      SEARCH: begin
        if (cand_valid && (cand > {1'b0, best_q})) begin
          best_d = cand[DW-1:0];
          a_d    = a_c;
          b_d    = bidx_q;
        end
        if (bidx_q == BW'(BMAX))
          state_d = EMIT;
        else
          bidx_d = bidx_q + 1'b1;
      end
      EMIT: begin
        // first EMIT cycle registers the term into the output stage
        if (!ov_q) begin
          ov_d = 1'b1;
          oa_d = a_q;
          ob_d = b_q;
          oz_d = (rem_q == '0);
          ol_d = (rem_q == best_q);
        end else if (bus.out_ready) begin
          ov_d  = 1'b0;
          rem_d = rem_q - best_q;
          if (ol_q) begin
            state_d = IDLE;
          end else begin
            state_d = SEARCH;
            bidx_d  = '0;
            best_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_a     = oa_q;
  assign bus.out_b     = ob_q;
  assign bus.out_zero  = oz_q;
  assign bus.out_last  = ol_q;
  assign busy          = (state_q != IDLE);

endmodule
